pll_reset_sequencer: RTL and testbench

//  Supervises the board PLL (25/50/100 MHz outputs). Drives the PLL reset and watches its asynchronous

---
 rtl/clkrst_pkg.sv | 22 ++
 rtl/sync2.sv | 22 ++
 rtl/pll_reset_sequencer.sv | 123 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/clkrst_pkg.sv
// Shared clock/reset definitions: supervisor state encodings and default PLL timing constants.
// Timing defaults assume the 50 MHz reference clock.
package clkrst_pkg;

    typedef enum logic [1:0] {
        ST_PLLRST = 2'b00,
        ST_WAIT   = 2'b01,
        ST_STABLE = 2'b10,
        ST_RUN    = 2'b11
    } state_t;

    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 1000000;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_CNT_W          = 20;

    // Diagnostic counters stick at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop bit synchronizer with asynchronous active-high reset.
// Output is d delayed by two clk edges; reset forces both stages to 0.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor on the 50 MHz reference clock: pulses the PLL reset, waits for a stable lock,
// then releases the system reset; re-resets the PLL on lock timeout, lock loss or request.
module pll_reset_sequencer
    import clkrst_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       locked,
    input  logic       req_rst,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    state_t           st;
    state_t           st_nxt;
    logic [CNT_W-1:0] cnt;
    logic             locked_s;
    logic             retry_inc;
    logic             loss_inc;
    logic             restart;

    sync2 u_sync_locked (
        .clk (clkin),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    // req_rst is a one-cycle strobe with no ready: it is sampled on every edge, always
    // accepted, and overrides any other transition evaluated on that edge.
    always_comb begin
        st_nxt    = st;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        if (req_rst) begin
            st_nxt = ST_PLLRST;
        end else begin
            case (st)
                ST_PLLRST: begin
                    if (cnt == PLL_LAST) st_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    // A lock arriving on the timeout cycle wins over the retry.
                    if (locked_s) begin
                        st_nxt = ST_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        st_nxt    = ST_PLLRST;
                        retry_inc = 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s)                st_nxt = ST_WAIT;
                    else if (cnt == STABLE_LAST)  st_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        st_nxt   = ST_PLLRST;
                        loss_inc = 1'b1;
                    end
                end
                default: st_nxt = ST_PLLRST;
            endcase
        end
        restart = req_rst || (st_nxt != st);
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            st <= ST_PLLRST;
        end else begin
            st <= st_nxt;
        end
    end

    // cnt holds at all-ones in RUN rather than wrapping; no decision there depends on it.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Outputs decode the next state so they move on the same edge as st.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
        end else begin
            pll_rst <= (st_nxt == ST_PLLRST);
            sys_rst <= (st_nxt != ST_RUN);
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            retry_cnt <= 8'h00;
            loss_cnt  <= 8'h00;
        end else begin
            if (retry_inc) retry_cnt <= sat_inc8(retry_cnt);
            if (loss_inc)  loss_cnt  <= sat_inc8(loss_cnt);
        end
    end

    assign ready = ~sys_rst;
    assign state = st;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: randomized lock timing, predicted edge counts
// derived from the timing rules (2-cycle sync + 1 decision edge + state durations).
module tb_pll_reset_sequencer;
    import clkrst_pkg::*;

    localparam int PLL_RST = 16;
    localparam int TIMEOUT = 256;
    localparam int STABLE  = 64;
    localparam int PERIOD  = PLL_RST + TIMEOUT;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       req_rst;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [1:0] state;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_retry   = 8'h00;
    logic [7:0] exp_loss    = 8'h00;
    logic [7:0] exp_q[$];

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (PLL_RST),
        .LOCK_TIMEOUT   (TIMEOUT),
        .STABLE_CYCLES  (STABLE),
        .CNT_W          (20)
    ) dut (
        .clkin     (clk),
        .rst       (rst),
        .locked    (locked),
        .req_rst   (req_rst),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .state     (state),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // All sampling and driving happens on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; locked = 1'b0; req_rst = 1'b0;
        #2;
        vectors++; if (state !== ST_PLLRST) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", state, ST_PLLRST); end
        vectors++; if (pll_rst !== 1'b1) begin miscompares++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
        vectors++; if (sys_rst !== 1'b1) begin miscompares++; $display("FAIL reset_sys_rst: got %b want 1", sys_rst); end
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", ready); end
        vectors++; if (retry_cnt !== 8'h00) begin miscompares++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
        vectors++; if (loss_cnt !== 8'h00) begin miscompares++; $display("FAIL reset_loss: got %0d want 0", loss_cnt); end
        step(3);
        vectors++; if (state !== ST_PLLRST) begin miscompares++; $display("FAIL reset_hold_state: got %0d want %0d", state, ST_PLLRST); end
        rst = 1'b0;
    endtask

    task automatic test_lock_sequence();
        int   d;
        logic e;
        for (int j = 1; j <= PLL_RST; j++) begin
            step(1);
            e = (j < PLL_RST);
            vectors++; if (pll_rst !== e) begin miscompares++; $display("FAIL seq_pll_rst_cycle%0d: got %b want %b", j, pll_rst, e); end
        end
        vectors++; if (state !== ST_WAIT) begin miscompares++; $display("FAIL seq_wait: got %0d want %0d", state, ST_WAIT); end
        d = int'($urandom_range(0, 200));
        step(d);
        locked = 1'b1;
        step(2);
        vectors++; if (state !== ST_WAIT) begin miscompares++; $display("FAIL seq_sync_latency: got %0d want %0d", state, ST_WAIT); end
        step(1);
        vectors++; if (state !== ST_STABLE) begin miscompares++; $display("FAIL seq_stable: got %0d want %0d", state, ST_STABLE); end
        step(STABLE - 1);
        vectors++; if (sys_rst !== 1'b1) begin miscompares++; $display("FAIL seq_sys_rst_early: got %b want 1", sys_rst); end
        step(1);
        vectors++; if (sys_rst !== 1'b0) begin miscompares++; $display("FAIL seq_sys_rst_release: got %b want 0", sys_rst); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL seq_ready: got %b want 1", ready); end
        vectors++; if (state !== ST_RUN) begin miscompares++; $display("FAIL seq_run: got %0d want %0d", state, ST_RUN); end
        vectors++; if (retry_cnt !== exp_retry) begin miscompares++; $display("FAIL seq_retry: got %0d want %0d", retry_cnt, exp_retry); end
    endtask

    task automatic test_lock_loss();
        logic e;
        step(int'($urandom_range(1, 20)));
        locked = 1'b0;
        step(2);
        vectors++; if (sys_rst !== 1'b0) begin miscompares++; $display("FAIL loss_sys_rst_early: got %b want 0", sys_rst); end
        step(1);
        exp_loss = sat_inc8(exp_loss);
        vectors++; if (sys_rst !== 1'b1) begin miscompares++; $display("FAIL loss_sys_rst: got %b want 1", sys_rst); end
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL loss_ready: got %b want 0", ready); end
        vectors++; if (state !== ST_PLLRST) begin miscompares++; $display("FAIL loss_state: got %0d want %0d", state, ST_PLLRST); end
        vectors++; if (loss_cnt !== exp_loss) begin miscompares++; $display("FAIL loss_cnt: got %0d want %0d", loss_cnt, exp_loss); end
        vectors++; if (pll_rst !== 1'b1) begin miscompares++; $display("FAIL loss_pll_rst_start: got %b want 1", pll_rst); end
        for (int j = 1; j <= PLL_RST; j++) begin
            step(1);
            e = (j < PLL_RST);
            vectors++; if (pll_rst !== e) begin miscompares++; $display("FAIL loss_pll_rst_cycle%0d: got %b want %b", j, pll_rst, e); end
        end
        vectors++; if (state !== ST_WAIT) begin miscompares++; $display("FAIL loss_wait: got %0d want %0d", state, ST_WAIT); end
    endtask

    task automatic test_stable_glitch();
        int g;
        int l;
        g = int'($urandom_range(5, 60));
        l = int'($urandom_range(1, 3));
        locked = 1'b1;
        step(g);
        locked = 1'b0;
        step(l);
        locked = 1'b1;
        step(3 - l);
        vectors++; if (state !== ST_WAIT) begin miscompares++; $display("FAIL glitch_back_to_wait: got %0d want %0d", state, ST_WAIT); end
        vectors++; if (sys_rst !== 1'b1) begin miscompares++; $display("FAIL glitch_sys_rst: got %b want 1", sys_rst); end
        step(l + STABLE - 1);
        vectors++; if (sys_rst !== 1'b1) begin miscompares++; $display("FAIL glitch_full_restart: got %b want 1", sys_rst); end
        vectors++; if (state !== ST_STABLE) begin miscompares++; $display("FAIL glitch_still_stable: got %0d want %0d", state, ST_STABLE); end
        step(1);
        vectors++; if (sys_rst !== 1'b0) begin miscompares++; $display("FAIL glitch_release: got %b want 0", sys_rst); end
        vectors++; if (state !== ST_RUN) begin miscompares++; $display("FAIL glitch_run: got %0d want %0d", state, ST_RUN); end
    endtask

    task automatic test_req_in_run();
        logic e;
        step(int'($urandom_range(1, 20)));
        locked = 1'b0;
        step(2);
        vectors++; if (state !== ST_RUN) begin miscompares++; $display("FAIL req_pre_run: got %0d want %0d", state, ST_RUN); end
        req_rst = 1'b1;
        step(1);
        req_rst = 1'b0;
        vectors++; if (state !== ST_PLLRST) begin miscompares++; $display("FAIL req_state: got %0d want %0d", state, ST_PLLRST); end
        vectors++; if (sys_rst !== 1'b1) begin miscompares++; $display("FAIL req_sys_rst: got %b want 1", sys_rst); end
        vectors++; if (loss_cnt !== exp_loss) begin miscompares++; $display("FAIL req_loss_unchanged: got %0d want %0d", loss_cnt, exp_loss); end
        vectors++; if (pll_rst !== 1'b1) begin miscompares++; $display("FAIL req_pll_rst_start: got %b want 1", pll_rst); end
        for (int j = 1; j <= PLL_RST; j++) begin
            step(1);
            e = (j < PLL_RST);
            vectors++; if (pll_rst !== e) begin miscompares++; $display("FAIL req_pll_rst_cycle%0d: got %b want %b", j, pll_rst, e); end
        end
        vectors++; if (loss_cnt !== exp_loss) begin miscompares++; $display("FAIL req_loss_after: got %0d want %0d", loss_cnt, exp_loss); end
    endtask

    task automatic test_retry_saturation();
        logic [7:0] want;
        req_rst = 1'b1;
        step(1);
        req_rst = 1'b0;
        for (int n = 1; n <= 256; n++) begin
            step(PLL_RST - 1);
            vectors++; if (pll_rst !== 1'b1) begin miscompares++; $display("FAIL retry%0d_pulse_high: got %b want 1", n, pll_rst); end
            step(1);
            vectors++; if (pll_rst !== 1'b0) begin miscompares++; $display("FAIL retry%0d_pulse_end: got %b want 0", n, pll_rst); end
            step(TIMEOUT - 1);
            vectors++; if (retry_cnt !== exp_retry) begin miscompares++; $display("FAIL retry%0d_before: got %0d want %0d", n, retry_cnt, exp_retry); end
            exp_retry = (n > 255) ? 8'hFF : 8'(n);
            exp_q.push_back(exp_retry);
            step(1);
            vectors++; if (pll_rst !== 1'b1) begin miscompares++; $display("FAIL retry%0d_repulse: got %b want 1", n, pll_rst); end
            want = exp_q.pop_front();
            vectors++; if (retry_cnt !== want) begin miscompares++; $display("FAIL retry%0d_count: got %0d want %0d", n, retry_cnt, want); end
        end
    endtask

    task automatic test_async_reset_mid_stable();
        locked  = 1'b1;
        req_rst = 1'b1;
        step(1);
        req_rst = 1'b0;
        step(PLL_RST + 1 + int'($urandom_range(5, 50)));
        vectors++; if (state !== ST_STABLE) begin miscompares++; $display("FAIL arst_pre_stable: got %0d want %0d", state, ST_STABLE); end
        #2 rst = 1'b1;
        #1;
        exp_retry = 8'h00;
        exp_loss  = 8'h00;
        vectors++; if (state !== ST_PLLRST) begin miscompares++; $display("FAIL arst_state: got %0d want %0d", state, ST_PLLRST); end
        vectors++; if (pll_rst !== 1'b1) begin miscompares++; $display("FAIL arst_pll_rst: got %b want 1", pll_rst); end
        vectors++; if (sys_rst !== 1'b1) begin miscompares++; $display("FAIL arst_sys_rst: got %b want 1", sys_rst); end
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL arst_ready: got %b want 0", ready); end
        vectors++; if (retry_cnt !== exp_retry) begin miscompares++; $display("FAIL arst_retry: got %0d want %0d", retry_cnt, exp_retry); end
        vectors++; if (loss_cnt !== exp_loss) begin miscompares++; $display("FAIL arst_loss: got %0d want %0d", loss_cnt, exp_loss); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        step(PLL_RST);
        vectors++; if (pll_rst !== 1'b0) begin miscompares++; $display("FAIL b2b_pll_rst: got %b want 0", pll_rst); end
        vectors++; if (state !== ST_WAIT) begin miscompares++; $display("FAIL b2b_wait: got %0d want %0d", state, ST_WAIT); end
        step(1);
        vectors++; if (state !== ST_STABLE) begin miscompares++; $display("FAIL b2b_stable: got %0d want %0d", state, ST_STABLE); end
        step(STABLE - 1);
        vectors++; if (sys_rst !== 1'b1) begin miscompares++; $display("FAIL b2b_sys_rst_early: got %b want 1", sys_rst); end
        step(1);
        vectors++; if (sys_rst !== 1'b0) begin miscompares++; $display("FAIL b2b_release: got %b want 0", sys_rst); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got %b want 1", ready); end
        vectors++; if (retry_cnt !== exp_retry) begin miscompares++; $display("FAIL b2b_retry: got %0d want %0d", retry_cnt, exp_retry); end
        vectors++; if (loss_cnt !== exp_loss) begin miscompares++; $display("FAIL b2b_loss: got %0d want %0d", loss_cnt, exp_loss); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_lock_sequence();
        test_lock_loss();
        test_stable_glitch();
        test_req_in_run();
        test_retry_saturation();
        test_async_reset_mid_stable();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
